// File: rtl/npu_pkg.sv
// Shared types and output formatting for the vector MAC block.
package npu_pkg;

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_e;

  localparam int NPU_LANES  = 4;
  localparam int NPU_DATA_W = 16;
  localparam int SAT_W      = 64;

  typedef logic [NPU_LANES-1:0][NPU_DATA_W-1:0] lane_vec_t;

  // Shift, optional ReLU, then clamp to a signed dw-bit range; callers truncate.
  function automatic logic signed [SAT_W-1:0] sat_shift(
    input logic signed [SAT_W-1:0] v,
    input int unsigned             shift,
    input int unsigned             dw,
    input logic                    relu
  );
    logic signed [SAT_W-1:0] s, mx, mn;
    s  = v >>> shift;
    mx = (64'sd1 <<< (dw - 1)) - 64'sd1;
    mn = -(64'sd1 <<< (dw - 1));
    if (relu && s < 0) return '0;
    if (s > mx) return mx;
    if (s < mn) return mn;
    return s;
  endfunction

endpackage

// File: rtl/npu_mac_lane.sv
// One MAC lane: accumulator plus registered, formatted result.
module npu_mac_lane
  import npu_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 35,
  parameter int SHIFT  = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] w,
  input  logic                     load,
  input  logic                     add,
  input  logic                     zero,
  input  logic                     cap,
  input  logic                     relu,
  output logic        [DATA_W-1:0] res
);

  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    acc_d, acc_q;
  logic        [DATA_W-1:0]   res_d, res_q;
  logic signed [SAT_W-1:0]    acc_wide;

  assign prod = a * w;

  always_comb begin
    acc_d = acc_q;
    if (zero)      acc_d = '0;
    else if (load) acc_d = ACC_W'(prod);
    else if (add)  acc_d = acc_q + ACC_W'(prod);
  end

  // Capture from the next-state accumulator so the result lands with the final beat.
  always_comb begin
    acc_wide = SAT_W'(acc_d);
    res_d    = res_q;
    if (cap) res_d = DATA_W'(sat_shift(acc_wide, SHIFT, DATA_W, relu));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      res_q <= '0;
    end else begin
      acc_q <= acc_d;
      res_q <= res_d;
    end
  end

  assign res = res_q;

endmodule

// File: rtl/npu_vec_mac.sv
// LANES-wide signed MAC with DEPTH-beat accumulation and valid/ready result port.
module npu_vec_mac
  import npu_pkg::*;
#(
  parameter int LANES  = 4,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8,
  parameter int SHIFT  = 0,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic                          in_valid,
  input  logic [LANES-1:0][DATA_W-1:0]  raw_in,
  input  logic [LANES-1:0][DATA_W-1:0]  weight_in,
  input  logic                          relu_en,
  input  logic                          clear,
  output logic [LANES-1:0][DATA_W-1:0]  raw_out,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          done,
  output logic [CNT_W-1:0]              countOut
);

  localparam int ACC_W = 2*DATA_W + $clog2(DEPTH);

  state_e           state_d, state_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             out_valid_d, out_valid_q;
  logic             done_d, done_q;
  logic             accept, last_beat, drain;

  assign accept    = enable & in_valid & (state_q != HOLD) & ~clear;
  assign last_beat = accept & (state_q == ACCUM) & (cnt_q == CNT_W'(DEPTH - 1));
  assign drain     = clear | ((state_q == HOLD) & out_ready);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    done_d      = 1'b0;
    if (clear) begin
      state_d     = IDLE;
      cnt_d       = '0;
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          state_d = ACCUM;
          cnt_d   = CNT_W'(1);
        end
        ACCUM: if (accept) begin
          cnt_d = cnt_q + 1'b1;
          if (last_beat) begin
            state_d     = HOLD;
            out_valid_d = 1'b1;
            done_d      = 1'b1;
          end
        end
        HOLD: if (out_ready) begin
          state_d     = IDLE;
          cnt_d       = '0;
          out_valid_d = 1'b0;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    npu_mac_lane #(.DATA_W(DATA_W), .ACC_W(ACC_W), .SHIFT(SHIFT)) u_lane (
      .clk  (clk),
      .rst  (rst),
      .a    (raw_in[g]),
      .w    (weight_in[g]),
      .load (accept & (state_q == IDLE)),
      .add  (accept & (state_q == ACCUM)),
      .zero (drain),
      .cap  (last_beat),
      .relu (relu_en),
      .res  (raw_out[g])
    );
  end

  assign out_valid = out_valid_q;
  assign done      = done_q;
  assign countOut  = cnt_q;

endmodule

// File: tb/tb_npu_vec_mac.sv
// Scoreboard bench for npu_vec_mac: directed plan cases plus randomized traffic.
module tb_npu_vec_mac;
  import npu_pkg::*;

  localparam int LANES  = NPU_LANES;
  localparam int DATA_W = NPU_DATA_W;
  localparam int DEPTH  = 8;
  localparam int SHIFT  = 0;
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam longint SMAX = (64'sd1 <<< (DATA_W - 1)) - 1;
  localparam longint SMIN = -(64'sd1 <<< (DATA_W - 1));

  logic             clk = 0;
  logic             rst = 1;
  logic             enable = 0, in_valid = 0, relu_en = 0, clear = 0, out_ready = 1;
  lane_vec_t        raw_in = '0, weight_in = '0;
  lane_vec_t        raw_out;
  logic             out_valid, done;
  logic [CNT_W-1:0] countOut;

  int vectors = 0, miscompares = 0;

  npu_vec_mac #(.LANES(LANES), .DATA_W(DATA_W), .DEPTH(DEPTH), .SHIFT(SHIFT)) dut (
    .clk(clk), .rst(rst), .enable(enable), .in_valid(in_valid),
    .raw_in(raw_in), .weight_in(weight_in), .relu_en(relu_en), .clear(clear),
    .raw_out(raw_out), .out_valid(out_valid), .out_ready(out_ready),
    .done(done), .countOut(countOut)
  );

  always #5 clk = ~clk;

  // Reference model: plain integer sums per lane, expected result queued on the last beat.
  lane_vec_t sb_q[$];
  longint    m_sum[LANES];
  int        m_cnt = 0;
  bit        m_hold = 0, m_done = 0;

  function automatic logic [DATA_W-1:0] ref_fmt(input longint s, input bit relu);
    longint v;
    v = s >>> SHIFT;
    if (relu && v < 0) v = 0;
    if (v > SMAX) v = SMAX;
    if (v < SMIN) v = SMIN;
    return DATA_W'(v);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt = 0; m_hold = 0; m_done = 0;
      foreach (m_sum[i]) m_sum[i] = 0;
      sb_q.delete();
    end else begin
      m_done = 0;
      if (clear) begin
        if (m_hold && sb_q.size() > 0) void'(sb_q.pop_front());
        m_cnt = 0; m_hold = 0;
        foreach (m_sum[i]) m_sum[i] = 0;
      end else if (m_hold) begin
        if (out_ready) begin
          if (sb_q.size() > 0) void'(sb_q.pop_front());
          m_hold = 0; m_cnt = 0;
          foreach (m_sum[i]) m_sum[i] = 0;
        end
      end else if (enable && in_valid) begin
        for (int i = 0; i < LANES; i++)
          m_sum[i] += longint'($signed(raw_in[i])) * longint'($signed(weight_in[i]));
        m_cnt++;
        if (m_cnt == DEPTH) begin
          lane_vec_t e;
          for (int i = 0; i < LANES; i++) e[i] = ref_fmt(m_sum[i], relu_en);
          sb_q.push_back(e);
          m_hold = 1; m_done = 1;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: checks every cycle against the model away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      chk("mon_count", 64'(countOut), 64'(m_cnt));
      chk("mon_valid", 64'(out_valid), 64'(m_hold));
      chk("mon_done", 64'(done), 64'(m_done));
      if (out_valid) begin
        if (sb_q.size() == 0) chk("mon_sb_underflow", 64'(sb_q.size()), 64'd1);
        else                  chk("mon_raw_out", 64'(raw_out), 64'(sb_q[0]));
      end
    end
  end

  function automatic lane_vec_t mk(input int a0, input int a1, input int a2, input int a3);
    lane_vec_t v;
    v[0] = DATA_W'(a0); v[1] = DATA_W'(a1); v[2] = DATA_W'(a2); v[3] = DATA_W'(a3);
    return v;
  endfunction

  task automatic tick(); @(posedge clk); #1; endtask

  task automatic beat(input lane_vec_t r, input lane_vec_t w);
    raw_in = r; weight_in = w; in_valid = 1; enable = 1;
    tick();
    in_valid = 0;
  endtask

  lane_vec_t ones, base;

  initial begin
    ones = mk(1, 1, 1, 1);
    base = mk(1, 2, 3, 4);
    #2;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_count", 64'(countOut), 64'd0);
    chk("rst_raw_out", 64'(raw_out), 64'd0);
    tick(); rst = 0;

    // basic accumulation
    for (int k = 0; k < DEPTH; k++) begin
      beat(base, ones);
      chk("basic_count", 64'(countOut), 64'(k + 1));
    end
    chk("basic_raw_out", 64'(raw_out), 64'(mk(8, 16, 24, 32)));
    chk("basic_valid", 64'(out_valid), 64'd1);
    chk("basic_done", 64'(done), 64'd1);
    tick();
    chk("basic_after_hs_valid", 64'(out_valid), 64'd0);
    chk("basic_after_hs_count", 64'(countOut), 64'd0);

    // stalls and gaps
    for (int k = 0; k < 4; k++) beat(base, ones);
    in_valid = 1; enable = 0;
    repeat (3) begin tick(); chk("stall_count", 64'(countOut), 64'd4); end
    for (int k = 0; k < 2; k++) beat(base, ones);
    enable = 1; in_valid = 0;
    repeat (2) begin tick(); chk("gap_count", 64'(countOut), 64'd6); end
    for (int k = 0; k < 2; k++) beat(base, ones);
    chk("stall_raw_out", 64'(raw_out), 64'(mk(8, 16, 24, 32)));
    tick();

    // saturation and ReLU
    for (int r = 0; r < 2; r++) begin
      relu_en = r[0];
      for (int k = 0; k < DEPTH; k++)
        beat(mk('h7FFF, 'h8000, -1, 0), mk('h7FFF, 'h7FFF, 5, 0));
      if (r == 0) chk("sat_raw_out", 64'(raw_out), 64'(mk(32767, -32768, -40, 0)));
      else        chk("relu_raw_out", 64'(raw_out), 64'(mk(32767, 0, 0, 0)));
      tick();
    end
    relu_en = 0;

    // backpressure
    out_ready = 0;
    for (int k = 0; k < DEPTH; k++) beat(base, ones);
    chk("bp_done_first", 64'(done), 64'd1);
    repeat (5) begin
      raw_in = mk(10, 20, 30, 40); in_valid = 1; enable = 1;
      tick();
      chk("bp_done_low", 64'(done), 64'd0);
      chk("bp_count", 64'(countOut), 64'(DEPTH));
      chk("bp_raw_out", 64'(raw_out), 64'(mk(8, 16, 24, 32)));
      chk("bp_valid", 64'(out_valid), 64'd1);
    end
    in_valid = 0; out_ready = 1;
    tick();
    chk("bp_release_valid", 64'(out_valid), 64'd0);
    chk("bp_release_count", 64'(countOut), 64'd0);

    // asynchronous reset mid-accumulation
    for (int k = 0; k < 5; k++) beat(base, ones);
    chk("pre_rst_count", 64'(countOut), 64'd5);
    #2 rst = 1;
    #1;
    chk("async_rst_count", 64'(countOut), 64'd0);
    chk("async_rst_valid", 64'(out_valid), 64'd0);
    chk("async_rst_raw_out", 64'(raw_out), 64'd0);
    chk("async_rst_done", 64'(done), 64'd0);
    tick(); rst = 0;

    // synchronous clear mid-accumulation
    for (int k = 0; k < 5; k++) beat(base, ones);
    clear = 1; in_valid = 1; enable = 1;
    tick();
    clear = 0; in_valid = 0;
    chk("clear_count", 64'(countOut), 64'd0);
    chk("clear_done", 64'(done), 64'd0);
    for (int k = 0; k < DEPTH; k++) beat(mk('hAAAA, 'h5555, 'hAAAA, 'h5555), ones);
    chk("clear_rerun_raw_out", 64'(raw_out), 64'(mk(-32768, 32767, -32768, 32767)));
    tick();

    // randomized traffic
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < LANES; i++) begin
        raw_in[i]    = DATA_W'($urandom);
        weight_in[i] = ($urandom_range(0, 3) == 0) ? DATA_W'($urandom) : DATA_W'($urandom_range(0, 15) - 8);
      end
      in_valid  = ($urandom_range(0, 3) != 0);
      enable    = ($urandom_range(0, 5) != 0);
      out_ready = ($urandom_range(0, 1) != 0);
      relu_en   = $urandom_range(0, 1) != 0;
      clear     = ($urandom_range(0, 59) == 0);
      tick();
    end
    clear = 0; in_valid = 0; out_ready = 1;
    repeat (3) tick();
    chk("sb_empty", 64'(sb_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/npu_vec_mac.md
Name: npu_vec_mac

Overview:
- Parametrised successor to the fixed 4-lane, 16-bit NPU datapath.
- LANES independent signed multiply-accumulate lanes. Each accepted beat adds raw_in[i]*weight_in[i] to lane i.
- After DEPTH accepted beats, the block presents scaled, saturated (optionally ReLU'd) results on a valid/ready output port and pulses done.
- Sits between the operand feeder and the activation/writeback stage of the NPU.

Parameters:
- LANES, 4: number of parallel MAC lanes.
- DATA_W, 16: signed operand and result width.
- DEPTH, 8: accepted beats per accumulation (>=2).
- SHIFT, 0: arithmetic right shift applied to the accumulator before saturation (0..DATA_W).
- CNT_W, $clog2(DEPTH+1): width of countOut (derived).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  advance permission; low stalls accumulation.
- in_valid  in  1  raw_in/weight_in carry a beat this cycle.
- raw_in  in  LANES x DATA_W  signed activation operands.
- weight_in  in  LANES x DATA_W  signed weight operands.
- relu_en  in  1  clamp negative results to 0; sampled at the final beat.
- clear  in  1  synchronous abort to IDLE; zeroes accumulators and count.
- raw_out  out  LANES x DATA_W  signed results, valid while out_valid.
- out_valid  out  1  results available.
- out_ready  in  1  downstream accepts results.
- done  out  1  one-cycle pulse on entry to HOLD.
- countOut  out  CNT_W  beats accepted in the current accumulation.

Behaviour:
- Reset (rst=1, asynchronous):
  - state=IDLE; all accumulators, raw_out, countOut, out_valid and done are 0.
  - Takes effect immediately, including mid-accumulation and mid-HOLD.
- Beat acceptance: accept = enable & in_valid & (state!=HOLD) & ~clear.
- States:
  - IDLE:
    - On accept, go to ACCUM.
    - acc[i] = product[i] (not added to the previous value); countOut=1.
  - ACCUM:
    - On accept, acc[i] += product[i] and countOut increments.
    - enable=0 or in_valid=0: acc and countOut hold.
    - When the accepted beat makes countOut==DEPTH, the next state is HOLD.
  - HOLD:
    - raw_out registered, out_valid=1, done=1 for the first HOLD cycle only.
    - Inputs are ignored.
    - On out_valid & out_ready: out_valid=0 next cycle, state=IDLE, countOut=0, acc cleared. The next beat may be accepted the cycle after.
- Latency: raw_out/out_valid rise on the clock edge after the DEPTH-th accepted beat (1 cycle).
- Back-to-back: no accept is possible in the handshake cycle itself.
- clear:
  - Highest priority below rst, in any state.
  - Drops out_valid; done is not pulsed.
- Arithmetic:
  - product = signed DATA_W x DATA_W -> 2*DATA_W.
  - acc width ACC_W = 2*DATA_W + $clog2(DEPTH), so accumulation never wraps.
  - Output = acc >>> SHIFT, then:
    - if relu_en and the value is negative -> 0;
    - otherwise saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- Per-lane results are independent; saturation in one lane does not affect the others.

Decomposition:
- Package npu_pkg:
  - state enum (IDLE, ACCUM, HOLD);
  - sat_shift function (shift + ReLU + saturate, parametrised by width);
  - lane-array typedefs.
- Sub-module npu_mac_lane: one lane holding the accumulator, product, and output formatting. Instantiated LANES times via generate.
- The top level owns the FSM, the counter and the handshake.

Test Plan:
- Basic (LANES=4, DEPTH=8, SHIFT=0): raw_in={1,2,3,4}, weight_in={1,1,1,1}, 8 beats with in_valid=enable=1.
  - countOut steps 1..8.
  - done pulses once.
  - raw_out={8,16,24,32} with out_valid=1 one cycle after beat 8.
- Stall/gap: same stimulus with enable=0 for 3 cycles after beat 4 and in_valid=0 for 2 cycles after beat 6.
  - countOut frozen during the gaps.
  - Final raw_out={8,16,24,32}.
- Saturation/ReLU: lane0 7FFF*7FFF; lane1 8000*7FFF; lane2 -1*5; lane3 0*0; 8 beats.
  - relu_en=0 -> {32767, -32768, -40, 0}.
  - relu_en=1 -> {32767, 0, 0, 0}.
- Backpressure: out_ready=0 for 5 cycles after HOLD is entered, with new valid inputs {10,20,30,40}.
  - out_valid and raw_out hold; done high in the first HOLD cycle only.
  - Inputs ignored; countOut stays 8.
  - out_ready=1 -> out_valid=0 and countOut=0 the next cycle.
- Reset/clear mid-operation:
  - rst=1 asynchronously at countOut=5 -> all outputs 0 before the next edge.
  - Separately, clear=1 at countOut=5 -> IDLE, countOut=0, no done pulse. A following 8-beat run of {0xAAAA,0x5555,...} with weights 1 gives raw_out = saturated per-lane sums {-32768, 32767, -32768, 32767}.
